frame_buf_ctrl: RTL

- Ping-pong frame buffer controller for the camera path.
- Splits the dual-port pixel RAM into two banks:
  - bank select is the MSB of the RAM address;
  - the capture side writes one bank while the display side drains the other.
- Generates all RAM addresses and write enables.
- Absorbs the RAM's 1-cycle read latency behind a valid/ready output stream.
- Drops whole frames when both banks are occupied.

---
 rtl/frame_buf_ctrl_if.sv | 31 +++
 rtl/frame_buf_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/frame_buf_ctrl_if.sv
// rtl/frame_buf_ctrl_if.sv - capture stream, display stream and dual-port RAM bus of the frame buffer
interface frame_buf_ctrl_if #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 14
);
    logic                     in_sof;
    logic                     in_valid;
    logic [RAM_WIDTH-1:0]     in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [RAM_WIDTH-1:0]     out_data;
    logic                     out_sof;
    logic                     out_eof;
    logic [RAM_ADDR_BITS-1:0] ram_addr_w;
    logic [RAM_WIDTH-1:0]     ram_data_w;
    logic                     ram_en_w;
    logic [RAM_ADDR_BITS-1:0] ram_addr_r;
    logic [RAM_WIDTH-1:0]     ram_data_r;

    modport slave (
        input  in_sof, in_valid, in_data, out_ready, ram_data_r,
        output out_valid, out_data, out_sof, out_eof,
               ram_addr_w, ram_data_w, ram_en_w, ram_addr_r
    );

    modport master (
        output in_sof, in_valid, in_data, out_ready, ram_data_r,
        input  out_valid, out_data, out_sof, out_eof,
               ram_addr_w, ram_data_w, ram_en_w, ram_addr_r
    );
endinterface

// File: rtl/frame_buf_ctrl.sv
// rtl/frame_buf_ctrl.sv - ping-pong frame buffer controller with 2-entry read-latency FIFO
module frame_buf_ctrl #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 14,
    parameter int FRAME_WORDS   = 8192
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_buf_ctrl_if.slave      bus,
    output logic [7:0]           drop_cnt
);
    localparam int PW = RAM_ADDR_BITS - 1;
    localparam logic [PW-1:0] LAST = PW'(FRAME_WORDS - 1);

    typedef enum logic {W_IDLE, W_FILL} wstate_t;

    wstate_t         wstate, wstate_nxt;
    logic            wbank, wbank_nxt;
    logic [PW-1:0]   wptr, wptr_nxt, wr_idx;
    logic            wr_en, drop_evt, set_full;
    logic [1:0]      bank_full, bank_full_nxt;

    logic            rbank;
    logic [PW-1:0]   rptr;
    logic            rd_done;
    logic            inflight, inflight_sof, inflight_eof;
    logic            issue, pop, frame_end;

    logic [RAM_WIDTH+1:0] fifo_mem [2];
    logic                 head, tail;
    logic [1:0]           fifo_count;
    logic [RAM_WIDTH+1:0] head_word;

    always_comb begin
        wstate_nxt = wstate;
        wptr_nxt   = wptr;
        wbank_nxt  = wbank;
        wr_idx     = wptr;
        wr_en      = 1'b0;
        drop_evt   = 1'b0;
        set_full   = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (bus.in_sof) begin
                    if (bank_full[wbank]) begin
                        drop_evt = 1'b1;
                    end else begin
                        wstate_nxt = W_FILL;
                        wptr_nxt   = '0;
                        wr_idx     = '0;
                        wr_en      = bus.in_valid;
                    end
                end
            end
            W_FILL: begin
                // A new sof restarts the same bank; its own pixel becomes word 0.
                if (bus.in_sof) begin
                    drop_evt = 1'b1;
                    wr_idx   = '0;
                    wptr_nxt = '0;
                end
                wr_en = bus.in_valid;
            end
            default: wstate_nxt = W_IDLE;
        endcase
        if (wr_en) begin
            if (wr_idx == LAST) begin
                set_full   = 1'b1;
                wbank_nxt  = ~wbank;
                wstate_nxt = W_IDLE;
                wptr_nxt   = '0;
            end else begin
                wptr_nxt = wr_idx + 1'b1;
            end
        end
    end

    assign bus.ram_en_w   = wr_en;
    assign bus.ram_addr_w = {wbank, wr_idx};
    assign bus.ram_data_w = bus.in_data;

    assign head_word     = fifo_mem[head];
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = head_word[RAM_WIDTH-1:0];
    assign bus.out_sof   = head_word[RAM_WIDTH+1];
    assign bus.out_eof   = head_word[RAM_WIDTH];
    assign bus.ram_addr_r = {rbank, rptr};

    assign pop       = bus.out_valid && bus.out_ready;
    assign frame_end = pop && head_word[RAM_WIDTH];
    // A word leaving this cycle frees a slot, which keeps the stream at one word per cycle.
    assign issue     = bank_full[rbank] && !rd_done &&
                       (((fifo_count + {1'b0, inflight}) < 2'd2) || pop);

    always_comb begin
        bank_full_nxt = bank_full;
        if (set_full)
            bank_full_nxt[wbank] = 1'b1;
        if (frame_end)
            bank_full_nxt[rbank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate       <= W_IDLE;
            wbank        <= 1'b0;
            wptr         <= '0;
            bank_full    <= 2'b00;
            drop_cnt     <= 8'd0;
            rbank        <= 1'b0;
            rptr         <= '0;
            rd_done      <= 1'b0;
            inflight     <= 1'b0;
            inflight_sof <= 1'b0;
            inflight_eof <= 1'b0;
            head         <= 1'b0;
            tail         <= 1'b0;
            fifo_count   <= 2'd0;
            for (int i = 0; i < 2; i++)
                fifo_mem[i] <= '0;
        end else begin
            wstate    <= wstate_nxt;
            wbank     <= wbank_nxt;
            wptr      <= wptr_nxt;
            bank_full <= bank_full_nxt;
            if (drop_evt && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            inflight     <= issue;
            inflight_sof <= (rptr == '0);
            inflight_eof <= (rptr == LAST);
            if (issue) begin
                if (rptr == LAST)
                    rd_done <= 1'b1;
                else
                    rptr <= rptr + 1'b1;
            end
            if (frame_end) begin
                rbank   <= ~rbank;
                rptr    <= '0;
                rd_done <= 1'b0;
            end

            if (inflight) begin
                fifo_mem[tail] <= {inflight_sof, inflight_eof, bus.ram_data_r};
                tail           <= ~tail;
            end
            if (pop)
                head <= ~head;
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule
